// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_port_arbiter_pkg                                              |
// | Purpose : Shared types and constants for the unified memory port arbiter:  |
// |           arbiter state encoding, abort word, fetch byte-enable and the    |
// |           fixed-priority winner selection helper.                          |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

  // Returned to the owner of an access that the watchdog aborted.
  localparam logic [31:0] c_ABORT_WORD = 32'hDEAD_BEEF;
  // Fetches are always full-word reads.
  localparam logic [3:0]  c_FETCH_BE   = 4'b1111;

  // Data side wins unless the fairness logic forces a fetch through.
  function automatic arb_state_e arb_pick(input logic d_req,
                                          input logic if_req,
                                          input logic force_if);
    if (d_req && !force_if) return ARB_BUSY_D;
    else if (if_req)        return ARB_BUSY_I;
    else                    return ARB_IDLE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_port_arbiter_if                                               |
// | Purpose : Bundles the fetch requester, data requester and memory port      |
// |           signals of the arbiter.                                          |
// | Modports: slave  - arbiter view (requests/memory response in, grants,      |
// |                    valids and memory command out)                          |
// |           master - environment view (requesters plus memory storage)       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // fetch requester
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  // data requester
  logic          d_req;
  logic          d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_valid;
  logic [DW-1:0] d_rdata;
  // memory port
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  // status
  logic          err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ready, mem_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ready, mem_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata, err
  );
endinterface
`default_nettype wire

// File: rtl/mem_arb_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_arb_timer                                                     |
// | Purpose : 8-bit watchdog counting cycles spent waiting on mem_ready.       |
// | Ports   : clk, reset (async, active-high)                                  |
// |           clr_i     - restart count (new grant)                            |
// |           en_i      - a busy cycle without mem_ready                       |
// |           expired_o - this waiting cycle is the TIMEOUT-th one             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mem_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // cnt_q holds the number of waiting cycles already elapsed, so the edge that
  // closes waiting cycle number TIMEOUT sees TIMEOUT-1 here.
  assign expired_o = en_i && (cnt_q == 8'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_port_arbiter                                                  |
// | Purpose : Shares one memory port between instruction fetch (IF) and        |
// |           load/store (D). Fixed D-over-IF priority, registered outputs,    |
// |           zero-bubble back-to-back grants and a mem_ready watchdog.        |
// | Ports   : clk, reset (async, active-high)                                  |
// |           bus - mem_port_arbiter_if.slave (requesters + memory port + err) |
// | Config  : MEM_ARB_FAIRNESS_EN - after MAX_DBURST consecutive D grants      |
// |           while IF waits, the next arbitration goes to IF.                 |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int TIMEOUT    = 255,
  parameter int MAX_DBURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  arb_state_e    state_q, state_d, pick;
  logic          if_gnt_q, if_gnt_d, if_valid_q, if_valid_d;
  logic          d_gnt_q, d_gnt_d, d_valid_q, d_valid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          err_q, err_d;
  logic          arb_en, force_if, tmr_expired;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (if_gnt_d | d_gnt_d),
    .en_i      ((state_q != ARB_IDLE) && !bus.mem_ready),
    .expired_o (tmr_expired)
  );

`ifdef MEM_ARB_FAIRNESS_EN
  logic [2:0] dburst_q, dburst_d;

  assign force_if = bus.if_req && (int'(dburst_q) >= MAX_DBURST);

  // Counts D grants that overtook a waiting fetch.
  always_comb begin
    dburst_d = dburst_q;
    if (!bus.if_req || if_gnt_d) dburst_d = '0;
    else if (d_gnt_d)            dburst_d = dburst_q + 3'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dburst_q <= '0;
    else       dburst_q <= dburst_d;
  end
`else
  logic unused_max_dburst;
  assign force_if          = 1'b0;
  assign unused_max_dburst = ^MAX_DBURST;
`endif

  always_comb begin
    state_d     = state_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    arb_en      = 1'b0;
    pick        = ARB_IDLE;

    case (state_q)
      ARB_IDLE: arb_en = 1'b1;
      ARB_BUSY_I, ARB_BUSY_D: begin
        // mem_ready is checked first so a completion on the expiry cycle wins.
        if (bus.mem_ready) begin
          arb_en    = 1'b1;
          mem_req_d = 1'b0;
          if (state_q == ARB_BUSY_D) begin
            d_valid_d = 1'b1;
            d_rdata_d = mem_we_q ? '0 : bus.mem_rdata;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end else if (tmr_expired) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ARB_IDLE;
          if (state_q == ARB_BUSY_D) begin
            d_valid_d = 1'b1;
            d_rdata_d = DW'(c_ABORT_WORD);
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = DW'(c_ABORT_WORD);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // Arbitration on the completion edge lets the next access start without
    // an idle cycle on mem_req.
    if (arb_en) begin
      pick    = arb_pick(bus.d_req, bus.if_req, force_if);
      state_d = pick;
      case (pick)
        ARB_BUSY_D: begin
          d_gnt_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_be_d    = bus.d_be;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
        end
        ARB_BUSY_I: begin
          if_gnt_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_be_d    = c_FETCH_BE;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mem_port_arbiter                                               |
// | Purpose : Scoreboard bench for mem_port_arbiter: a memory model with       |
// |           programmable latency/stall, expected memory commands and         |
// |           responses queued when requests are driven.                       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_ARB_FAIRNESS_EN
  localparam int EXP_IF_AFTER = 4;
`else
  localparam int EXP_IF_AFTER = 6;
`endif

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_acc_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT(255), .MAX_DBURST(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] if_exp_q[$];
  logic [31:0] d_exp_q[$];
  mem_acc_t    mem_exp_q[$];
  int lat   = 0;
  bit stall = 1'b0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'h2010_0014;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic push_if(input logic [31:0] a);
    mem_exp_q.push_back({1'b0, 4'hF, a, 32'h0});
    if_exp_q.push_back(mem_val(a));
  endtask

  task automatic push_d(input logic we, input logic [3:0] be, input logic [31:0] a,
                        input logic [31:0] wd);
    mem_exp_q.push_back({we, be, a, wd});
    d_exp_q.push_back(we ? 32'h0 : mem_val(a));
  endtask

  task automatic wait_gnt(input bit is_d, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(is_d ? bus.d_gnt : bus.if_gnt) && cyc < 50);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((if_exp_q.size() != 0 || d_exp_q.size() != 0 || mem_exp_q.size() != 0 ||
            bus.mem_req) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(n < 2000), 32'd1);
    @(negedge clk);
  endtask

  // Memory model and response scoreboard, evaluated away from the active edge.
  initial begin : mon
    int       wait_cnt;
    bit       acc_start;
    mem_acc_t e;
    logic [31:0] x;
    wait_cnt      = 0;
    acc_start     = 1'b1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bus.mem_ready = 1'b0;
        acc_start     = 1'b1;
        wait_cnt      = 0;
      end else begin
        if (bus.if_valid) begin
          if (if_exp_q.size() == 0) check("if_valid_unexpected", 32'd1, 32'd0);
          else begin
            x = if_exp_q.pop_front();
            check("if_rdata", bus.if_rdata, x);
          end
        end
        if (bus.d_valid) begin
          if (d_exp_q.size() == 0) check("d_valid_unexpected", 32'd1, 32'd0);
          else begin
            x = d_exp_q.pop_front();
            check("d_rdata", bus.d_rdata, x);
          end
        end
        if (bus.mem_req) begin
          if (acc_start) begin
            acc_start = 1'b0;
            wait_cnt  = 0;
            if (mem_exp_q.size() == 0) check("mem_req_unexpected", 32'd1, 32'd0);
            else begin
              e = mem_exp_q.pop_front();
              check("mem_we", 32'(bus.mem_we), 32'(e.we));
              check("mem_be", 32'(bus.mem_be), 32'(e.be));
              check("mem_addr", bus.mem_addr, e.addr);
              if (e.we) check("mem_wdata", bus.mem_wdata, e.wdata);
            end
          end
          if (!stall && wait_cnt >= lat) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = mem_val(bus.mem_addr);
            acc_start     = 1'b1;
          end else begin
            bus.mem_ready = 1'b0;
            wait_cnt++;
          end
        end else begin
          bus.mem_ready = 1'b0;
          acc_start     = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc, n, dg, ifat;
    logic [31:0] a, wd;
    logic [3:0]  be;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mem_req",  32'(bus.mem_req),  32'd0);
    check("rst_if_gnt",   32'(bus.if_gnt),   32'd0);
    check("rst_d_gnt",    32'(bus.d_gnt),    32'd0);
    check("rst_if_valid", 32'(bus.if_valid), 32'd0);
    check("rst_d_valid",  32'(bus.d_valid),  32'd0);
    check("rst_err",      32'(bus.err),      32'd0);
    check("rst_d_rdata",  bus.d_rdata,       32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Fetch only, memory answers in the first busy cycle.
    lat = 0;
    push_if(32'h10);
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    @(negedge clk);
    check("t1_if_gnt",  32'(bus.if_gnt),  32'd1);
    check("t1_mem_req", 32'(bus.mem_req), 32'd1);
    check("t1_mem_we",  32'(bus.mem_we),  32'd0);
    bus.if_req = 1'b0;
    @(negedge clk);
    check("t1_if_valid", 32'(bus.if_valid), 32'd1);
    check("t1_if_rdata", bus.if_rdata, 32'h2010_0004);
    wait_idle();

    // Collision: D first, IF granted on the D completion edge.
    push_d(1'b0, 4'hF, 32'h40, 32'h0);
    push_if(32'h20);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h40;
    bus.if_req = 1'b1; bus.if_addr = 32'h20;
    @(negedge clk);
    check("t2_d_gnt",    32'(bus.d_gnt),  32'd1);
    check("t2_if_nogrant", 32'(bus.if_gnt), 32'd0);
    check("t2_mem_addr", bus.mem_addr, 32'h40);
    bus.d_req = 1'b0;
    @(negedge clk);
    check("t2_if_gnt",   32'(bus.if_gnt),  32'd1);
    check("t2_d_valid",  32'(bus.d_valid), 32'd1);
    check("t2_no_bubble", 32'(bus.mem_req), 32'd1);
    check("t2_mem_addr_if", bus.mem_addr, 32'h20);
    bus.if_req = 1'b0;
    wait_idle();

    // Store: rdata returns 0 even though memory drives nonzero data.
    push_d(1'b1, 4'b0011, 32'h80, 32'hCAFE_F00D);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011;
    bus.d_addr = 32'h80; bus.d_wdata = 32'hCAFE_F00D;
    wait_gnt(1'b1, cyc);
    check("t3_gnt_cycles", 32'(cyc), 32'd1);
    check("t3_mem_we", 32'(bus.mem_we), 32'd1);
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    wait_idle();

    // Mixed traffic with two wait cycles per access.
    lat = 2;
    for (int i = 0; i < 6; i++) begin
      a  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      wd = $urandom;
      be = 4'($urandom_range(1, 15));
      if (i % 3 == 0) begin
        push_if(a);
        bus.if_req = 1'b1; bus.if_addr = a;
        wait_gnt(1'b0, cyc);
        bus.if_req = 1'b0;
      end else begin
        push_d(i % 3 == 2, be, a, wd);
        bus.d_req = 1'b1; bus.d_we = (i % 3 == 2); bus.d_be = be;
        bus.d_addr = a; bus.d_wdata = wd;
        wait_gnt(1'b1, cyc);
        bus.d_req = 1'b0; bus.d_we = 1'b0;
      end
      check("mix_gnt_cycles", 32'(cyc), 32'd1);
      wait_idle();
    end

    // mem_ready arriving on the expiry cycle completes normally.
    lat = 254;
    push_d(1'b0, 4'hF, 32'h44, 32'h0);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h44;
    wait_gnt(1'b1, cyc);
    bus.d_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.d_valid && n < 400);
    check("tb_edge_cycles", 32'(n), 32'd255);
    check("tb_edge_err", 32'(bus.err), 32'd0);
    lat = 0;
    wait_idle();

    // Timeout abort.
    stall = 1'b1;
    mem_exp_q.push_back({1'b0, 4'hF, 32'h48, 32'h0});
    d_exp_q.push_back(32'hDEAD_BEEF);
    bus.d_req = 1'b1; bus.d_addr = 32'h48;
    wait_gnt(1'b1, cyc);
    bus.d_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.d_valid && n < 400);
    check("t4_timeout_cycles", 32'(n), 32'd255);
    check("t4_err", 32'(bus.err), 32'd1);
    check("t4_mem_req", 32'(bus.mem_req), 32'd0);
    stall = 1'b0;
    push_if(32'h50);
    bus.if_req = 1'b1; bus.if_addr = 32'h50;
    wait_gnt(1'b0, cyc);
    bus.if_req = 1'b0;
    wait_idle();
    check("t4_err_sticky", 32'(bus.err), 32'd1);

    // Reset during a stalled data access: access dropped, no valid.
    stall = 1'b1;
    mem_exp_q.push_back({1'b0, 4'hF, 32'h60, 32'h0});
    bus.d_req = 1'b1; bus.d_addr = 32'h60;
    wait_gnt(1'b1, cyc);
    bus.d_req = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t5_mem_req", 32'(bus.mem_req), 32'd0);
    check("t5_err_cleared", 32'(bus.err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_no_d_valid", 32'(bus.d_valid), 32'd0);
    push_if(32'h70);
    bus.if_req = 1'b1; bus.if_addr = 32'h70;
    wait_gnt(1'b0, cyc);
    check("t5_if_gnt_cycles", 32'(cyc), 32'd1);
    bus.if_req = 1'b0;
    wait_idle();

    // D held for six accesses while a fetch waits.
    for (int k = 0; k < 6; k++) begin
      if (k == EXP_IF_AFTER) mem_exp_q.push_back({1'b0, 4'hF, 32'h200, 32'h0});
      push_d(1'b0, 4'hF, 32'h100, 32'h0);
    end
    if (EXP_IF_AFTER >= 6) mem_exp_q.push_back({1'b0, 4'hF, 32'h200, 32'h0});
    if_exp_q.push_back(mem_val(32'h200));
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h100;
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    dg = 0; ifat = -1; n = 0;
    while ((dg < 6 || ifat < 0) && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.d_gnt) begin
        dg++;
        if (dg == 6) bus.d_req = 1'b0;
      end
      if (bus.if_gnt) begin
        ifat = dg;
        bus.if_req = 1'b0;
      end
    end
    bus.d_req = 1'b0; bus.if_req = 1'b0;
    check("t6_if_gnt_after_dgrants", 32'(ifat), 32'(EXP_IF_AFTER));
    check("t6_d_grants", 32'(dg), 32'd6);
    wait_idle();

    check("final_queues_empty",
          32'(if_exp_q.size() + d_exp_q.size() + mem_exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
